// File: rtl/uart_if.sv
// UART port bundle: parallel transmit request/data, received word and the two serial lines.
// The master side (a host or testbench) drives the request, the word to send and the receive
// line; the slave side (the UART) drives the received word and the transmit line.
interface uart_if #(
    parameter int N = 8
);
    logic [N-1:0] tx_data;
    logic         transmit;
    logic         serial_rx;
    logic [N-1:0] rx_data;
    logic         serial_tx;

    modport master (
        output tx_data,
        output transmit,
        output serial_rx,
        input  rx_data,
        input  serial_tx
    );

    modport slave (
        input  tx_data,
        input  transmit,
        input  serial_rx,
        output rx_data,
        output serial_tx
    );
endinterface

// File: rtl/uart.sv
// Full-duplex UART: 8N1-style framing (1 start, N data LSB first, 1 stop, no parity).
// The transmitter and receiver are independent FSMs sharing only clk and rst.
module uart #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    uart_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] WORD_LAST = BW'(N - 1);

    // ---------------- transmitter ----------------
    state_t         tx_state, tx_state_nx;
    logic [CW-1:0]  tx_cnt, tx_cnt_nx;
    logic [BW-1:0]  tx_bit, tx_bit_nx;
    logic [N-1:0]   tx_shift, tx_shift_nx;
    logic           tx_line, tx_line_nx;

    // TX state, counters, shift register and the registered serial line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_shift <= tx_shift_nx;
            tx_line  <= tx_line_nx;
        end
    end

    // TX next-state logic; the line value is derived from the next state so serial_tx is a flop output.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a signal unassigned (no latches).
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt;
        tx_bit_nx   = tx_bit;
        tx_shift_nx = tx_shift;
        unique case (tx_state)
            IDLE: begin
                if (bus.transmit) begin
                    tx_shift_nx = bus.tx_data;
                    tx_cnt_nx   = '0;
                    tx_bit_nx   = '0;
                    tx_state_nx = START;
                end
            end
            START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_state_nx = DATA;
                end else begin
                    tx_cnt_nx = tx_cnt + CW'(1);
                end
            end
            DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_shift_nx = tx_shift >> 1;
                    if (tx_bit == WORD_LAST) begin
                        tx_bit_nx   = '0;
                        tx_state_nx = STOP;
                    end else begin
                        tx_bit_nx = tx_bit + BW'(1);
                    end
                end else begin
                    tx_cnt_nx = tx_cnt + CW'(1);
                end
            end
            STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_nx   = '0;
                    tx_state_nx = IDLE;
                end else begin
                    tx_cnt_nx = tx_cnt + CW'(1);
                end
            end
            default: tx_state_nx = IDLE;
        endcase

        unique case (tx_state_nx)
            START:   tx_line_nx = 1'b0;
            DATA:    tx_line_nx = tx_shift_nx[0];
            default: tx_line_nx = 1'b1;
        endcase
    end

    assign bus.serial_tx = tx_line;

    // ---------------- receiver ----------------
    logic           rx_meta, rx_sync;
    state_t         rx_state, rx_state_nx;
    logic [CW-1:0]  rx_cnt, rx_cnt_nx;
    logic [BW-1:0]  rx_bit, rx_bit_nx;
    logic [N-1:0]   rx_shift, rx_shift_nx;
    logic [N-1:0]   rx_word, rx_word_nx;

    // Two-flop synchronizer; resets to the idle-high level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.serial_rx;
            rx_sync <= rx_meta;
        end
    end

    // RX state, counters, shift register and the held received word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_word  <= '0;
        end else begin
            rx_state <= rx_state_nx;
            rx_cnt   <= rx_cnt_nx;
            rx_bit   <= rx_bit_nx;
            rx_shift <= rx_shift_nx;
            rx_word  <= rx_word_nx;
        end
    end

    // RX next-state logic: confirm the start bit at its midpoint, then sample once per bit period.
    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt;
        rx_bit_nx   = rx_bit;
        rx_shift_nx = rx_shift;
        rx_word_nx  = rx_word;
        unique case (rx_state)
            IDLE: begin
                if (!rx_sync) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = START;
                end
            end
            START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_bit_nx   = '0;
                    rx_state_nx = rx_sync ? IDLE : DATA;
                end else begin
                    rx_cnt_nx = rx_cnt + CW'(1);
                end
            end
            DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_shift_nx = {rx_sync, rx_shift[N-1:1]};
                    if (rx_bit == WORD_LAST) begin
                        rx_bit_nx   = '0;
                        rx_state_nx = STOP;
                    end else begin
                        rx_bit_nx = rx_bit + BW'(1);
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + CW'(1);
                end
            end
            STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = IDLE;
                    if (rx_sync) begin
                        rx_word_nx = rx_shift;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + CW'(1);
                end
            end
            default: rx_state_nx = IDLE;
        endcase
    end

    assign bus.rx_data = rx_word;

endmodule

// File: tb/tb_uart.sv
// Directed bench for the UART: reset, loopback, busy ignore, back-to-back frames,
// receiver glitch/framing rejection and mid-frame reset recovery.
module tb_uart;
    localparam int N   = 8;
    localparam int CPB = 16;

    logic clk;
    logic rst;
    logic loop_en;
    logic rx_drive;

    int n_checks;
    int n_fail;

    uart_if #(.N(N)) bus ();

    uart #(.N(N), .CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.serial_rx = loop_en ? bus.serial_tx : rx_drive;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the first cycle of a start bit; samples serial_tx mid-bit for all 10 bits.
    // With inject set, a transmit request with 0xFF is raised mid-frame and dropped before STOP.
    task automatic check_frame(input logic [7:0] d, input bit inject);
        logic exp_bit;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      exp_bit = 1'b0;
            else if (i == 9) exp_bit = 1'b1;
            else             exp_bit = d[i-1];
            repeat (CPB / 2) tick;
            check($sformatf("tx_%0h_bit%0d", d, i), {31'd0, bus.serial_tx}, {31'd0, exp_bit});
            if (inject && i == 3) begin
                bus.transmit = 1'b1;
                bus.tx_data  = 8'hFF;
            end
            if (inject && i == 6) bus.transmit = 1'b0;
            repeat (CPB - CPB / 2) tick;
        end
    endtask

    // Drives a complete frame on serial_rx with a chosen stop-bit level.
    task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      rx_drive = 1'b0;
            else if (i == 9) rx_drive = stop_bit;
            else             rx_drive = d[i-1];
            repeat (CPB) tick;
        end
        rx_drive = 1'b1;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b0;
        loop_en      = 1'b0;
        rx_drive     = 1'b1;
        bus.transmit = 1'b0;
        bus.tx_data  = 8'h00;

        // Reset held with toggling inputs.
        for (int i = 0; i < 8; i++) begin
            bus.transmit = ~bus.transmit;
            bus.tx_data  = 8'($urandom);
            rx_drive     = ~rx_drive;
            tick;
            check("rst_serial_tx", {31'd0, bus.serial_tx}, 32'd1);
            check("rst_rx_data", {24'd0, bus.rx_data}, 32'h00);
        end
        bus.transmit = 1'b0;
        rx_drive     = 1'b1;
        loop_en      = 1'b1;
        tick;
        rst = 1'b1;
        repeat (4) tick;
        check("idle_serial_tx", {31'd0, bus.serial_tx}, 32'd1);

        // Loopback 0x55 with a one-cycle pulse.
        bus.tx_data  = 8'h55;
        bus.transmit = 1'b1;
        tick;
        bus.transmit = 1'b0;
        check_frame(8'h55, 1'b0);
        check("loop_rx_55", {24'd0, bus.rx_data}, 32'h55);
        repeat (CPB) tick;

        // Busy: request with 0xFF during the 0xA3 frame is ignored.
        bus.tx_data  = 8'hA3;
        bus.transmit = 1'b1;
        tick;
        bus.transmit = 1'b0;
        check_frame(8'hA3, 1'b1);
        check("busy_rx_a3", {24'd0, bus.rx_data}, 32'hA3);
        repeat (2 * CPB) tick;
        check("busy_no_second", {31'd0, bus.serial_tx}, 32'd1);
        check("busy_rx_hold", {24'd0, bus.rx_data}, 32'hA3);

        // Back-to-back: transmit held high, word changes after acceptance.
        bus.tx_data  = 8'h00;
        bus.transmit = 1'b1;
        tick;
        bus.tx_data = 8'hFF;
        check_frame(8'h00, 1'b0);
        check("b2b_gap_idle", {31'd0, bus.serial_tx}, 32'd1);
        check("b2b_rx_00", {24'd0, bus.rx_data}, 32'h00);
        tick;
        bus.transmit = 1'b0;
        check_frame(8'hFF, 1'b0);
        check("b2b_rx_ff", {24'd0, bus.rx_data}, 32'hFF);
        repeat (2 * CPB) tick;

        // Receiver robustness on a directly driven line.
        loop_en = 1'b0;
        drive_frame(8'h5A, 1'b1);
        repeat (CPB) tick;
        check("rx_valid_5a", {24'd0, bus.rx_data}, 32'h5A);
        rx_drive = 1'b0;
        tick;
        rx_drive = 1'b1;
        repeat (3 * CPB) tick;
        check("rx_glitch", {24'd0, bus.rx_data}, 32'h5A);
        drive_frame(8'hC3, 1'b0);
        repeat (11 * CPB) tick;
        check("rx_frame_err", {24'd0, bus.rx_data}, 32'h5A);

        // Mid-frame reset during DATA, then recovery.
        loop_en      = 1'b1;
        bus.tx_data  = 8'h3C;
        bus.transmit = 1'b1;
        tick;
        bus.transmit = 1'b0;
        repeat (4 * CPB) tick;
        check("mid_in_data", {31'd0, bus.serial_tx}, {31'd0, 1'b1});
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tx", {31'd0, bus.serial_tx}, 32'd1);
        check("mid_rst_rx", {24'd0, bus.rx_data}, 32'h00);
        repeat (3) tick;
        rst = 1'b1;
        repeat (20) tick;
        check("post_rst_idle", {31'd0, bus.serial_tx}, 32'd1);
        rst = 1'b0;
        tick;
        bus.tx_data  = 8'h3C;
        bus.transmit = 1'b1;
        rst          = 1'b1;
        tick;
        bus.transmit = 1'b0;
        check_frame(8'h3C, 1'b0);
        check("mid_rx_3c", {24'd0, bus.rx_data}, 32'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart.md
UART -- requirements
Module: uart

Interface
REQ-001 Parameter N, default 8: data word width in bits.
REQ-002 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit period, legal range ≥4.
REQ-003 clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 tx_data  input  N  word to transmit; sampled when a transmit request is accepted.
REQ-006 transmit  input  1  transmit request, level-sampled each clk.
REQ-007 serial_rx  input  1  asynchronous serial receive line, idle high.
REQ-008 rx_data  output  N  last correctly framed received word.
REQ-009 serial_tx  output  1  serial transmit line, idle high.

Function
REQ-010 Frame format SHALL be: 1 start bit (0), N data bits LSB first, 1 stop bit (1), no parity; each bit lasts exactly CLKS_PER_BIT clk cycles.
REQ-011 TX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-012 TX IDLE: serial_tx=1; when transmit=1 at a rising edge, latch tx_data into a shift register, clear the bit counter, go to START.
REQ-013 TX START: serial_tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-014 TX DATA: drive the shift register LSB for CLKS_PER_BIT cycles per bit, shift right, after N bits go to STOP.
REQ-015 TX STOP: serial_tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-016 serial_tx SHALL be registered and glitch-free; the first start-bit cycle appears 1 clk after the accepting edge.
REQ-017 transmit asserted outside IDLE SHALL be ignored; tx_data changes after acceptance SHALL NOT affect the frame in flight.
REQ-018 transmit held high continuously SHALL start back-to-back frames; a new frame is accepted on the first IDLE cycle after STOP.
REQ-019 serial_rx SHALL pass through a 2-flop synchronizer before use.
REQ-020 RX FSM SHALL have states IDLE, START, DATA, STOP.
REQ-021 RX IDLE: on synchronized serial_rx=0, go to START.
REQ-022 RX START: re-sample at CLKS_PER_BIT/2 cycles; if still 0, go to DATA, else return to IDLE (glitch rejection).
REQ-023 RX DATA: sample every CLKS_PER_BIT cycles from the start-bit midpoint, shifting bits in LSB first, N samples.
REQ-024 RX STOP: sample 1 bit period later; if 1, load rx_data with the assembled word; if 0 (framing error), leave rx_data unchanged; in both cases return to IDLE.
REQ-025 rx_data SHALL change only on a valid stop bit and hold otherwise.
REQ-026 TX and RX SHALL be independent and full-duplex; serial_tx tied to serial_rx (loopback) SHALL deliver tx_data to rx_data.

Reset
REQ-027 While rst=0: serial_tx=1, rx_data=0, both FSMs IDLE, all counters and shift registers 0; applies immediately, without waiting for clk.
REQ-028 Reset asserted mid-frame SHALL abort both frames; after release, serial_tx stays 1 until a new transmit is accepted.
REQ-029 transmit=1 on the first clk edge after rst rises SHALL be accepted normally.

Verification
REQ-030 Reset: rst=0 with toggling inputs -> serial_tx=1, rx_data=0x00 throughout.
REQ-031 Loopback: serial_tx tied to serial_rx, release rst, pulse transmit for 1 clk with tx_data=0x55 -> serial_tx shows 0,1,0,1,0,1,0,1,0,1 per bit period, and rx_data=0x55 within 10*CLKS_PER_BIT+4 clks.
REQ-032 Busy ignore: send 0xA3, assert transmit with tx_data=0xFF mid-frame -> only 0xA3 is transmitted and received.
REQ-033 Back-to-back: transmit held high with tx_data=0x00 then 0xFF -> two contiguous frames, rx_data=0x00 then 0xFF.
REQ-034 RX robustness: drive a 1-clk low glitch on serial_rx -> rx_data unchanged; drive a frame with stop bit 0 -> rx_data unchanged.
REQ-035 Mid-frame reset: assert rst=0 during DATA -> serial_tx=1 immediately; the next transmit of 0x3C completes correctly.
